// File: rtl/prefix_ctl_pkg.sv
// Shared prefix-vector layout, FSM encoding and per-byte prefix classification
// for the x86 legacy/REX prefix sequencer.
package prefix_ctl_pkg;

    localparam int pref_width = 15;
    localparam int MAXPRF     = 14;

    localparam int pref_LOCK   = 0;
    localparam int pref_REPN   = 1;
    localparam int pref_REPE   = 2;
    localparam int pref_DATA   = 3;
    localparam int pref_ADDR   = 4;
    localparam int pref_2BYTE  = 5;
    localparam int pref_HASSEG = 6;
    localparam int pref_SEG    = 7;   // 3-bit field, ES=0 CS=1 SS=2 DS=3 FS=4 GS=5
    localparam int pref_REX    = 10;
    localparam int pref_W      = 11;
    localparam int pref_R      = 12;
    localparam int pref_X      = 13;
    localparam int pref_B      = 14;

    localparam logic [pref_width-1:0] SEG_MASK = 15'h0380;

    typedef enum logic [1:0] {
        PRFCTL_SCAN = 2'd0,
        PRFCTL_DONE = 2'd1,
        PRFCTL_ERR  = 2'd2
    } prfctl_state_t;

    typedef struct packed {
        logic                  hit;
        logic                  term;
        logic                  rex;
        logic [pref_width-1:0] bits;
    } prf_byte_t;

    // OR all flags; a chunk carrying a segment override replaces the SEG field.
    function automatic logic [pref_width-1:0] prf_merge(
        input logic [pref_width-1:0] acc,
        input logic [pref_width-1:0] nxt
    );
        if (nxt[pref_HASSEG]) begin
            return (acc & ~SEG_MASK) | nxt;
        end
        return acc | nxt;
    endfunction

    function automatic prf_byte_t prf_decode_byte(
        input logic [7:0] b,
        input logic       m64
    );
        prf_byte_t d;
        d = '0;
        d.hit = 1'b1;
        case (b)
            8'hF0: d.bits[pref_LOCK]  = 1'b1;
            8'hF2: d.bits[pref_REPN]  = 1'b1;
            8'hF3: d.bits[pref_REPE]  = 1'b1;
            8'h66: d.bits[pref_DATA]  = 1'b1;
            8'h67: d.bits[pref_ADDR]  = 1'b1;
            8'h0F: begin
                d.bits[pref_2BYTE] = 1'b1;
                d.term = 1'b1;
            end
            8'h26: begin d.bits[pref_HASSEG] = 1'b1; d.bits[pref_SEG +: 3] = 3'd0; end
            8'h2E: begin d.bits[pref_HASSEG] = 1'b1; d.bits[pref_SEG +: 3] = 3'd1; end
            8'h36: begin d.bits[pref_HASSEG] = 1'b1; d.bits[pref_SEG +: 3] = 3'd2; end
            8'h3E: begin d.bits[pref_HASSEG] = 1'b1; d.bits[pref_SEG +: 3] = 3'd3; end
            8'h64: begin d.bits[pref_HASSEG] = 1'b1; d.bits[pref_SEG +: 3] = 3'd4; end
            8'h65: begin d.bits[pref_HASSEG] = 1'b1; d.bits[pref_SEG +: 3] = 3'd5; end
            default: begin
                if (m64 && (b[7:4] == 4'h4)) begin
                    d.rex  = 1'b1;
                    d.term = 1'b1;
                    d.bits[pref_REX] = 1'b1;
                    d.bits[pref_W]   = b[3];
                    d.bits[pref_R]   = b[2];
                    d.bits[pref_X]   = b[1];
                    d.bits[pref_B]   = b[0];
                end else begin
                    d.hit = 1'b0;
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/prefix_ctl_prefix.sv
// Prefix decoder for one 4-byte window: counts the leading prefix bytes and
// folds them into a single prefix vector. A REX or 0x0F byte ends the run.
module prefix_ctl_prefix
    import prefix_ctl_pkg::*;
(
    input  logic [31:0]           i_bits,
    input  logic                  i_mode64,
    output logic [2:0]            o_bytes,
    output logic [pref_width-1:0] o_pref,
    output logic                  o_rex_end
);

    prf_byte_t             w_dec [4];
    logic                  w_run;
    logic [2:0]            w_n;
    logic [pref_width-1:0] w_pref;
    logic                  w_rex_end;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign w_dec[gi] = prf_decode_byte(i_bits[8*gi +: 8], i_mode64);
        end
    endgenerate

    always_comb begin
        w_run     = 1'b1;
        w_n       = 3'd0;
        w_pref    = '0;
        w_rex_end = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_run) begin
                if (w_dec[i].hit) begin
                    w_pref = prf_merge(w_pref, w_dec[i].bits);
                    w_n    = w_n + 3'd1;
                    if (w_dec[i].term) begin
                        w_run     = 1'b0;
                        w_rex_end = w_dec[i].rex;
                    end
                end else begin
                    w_run = 1'b0;
                end
            end
        end
    end

    assign o_bytes   = w_n;
    assign o_pref    = w_pref;
    assign o_rex_end = w_rex_end;

endmodule

// File: rtl/prefix_ctl.sv
// Prefix sequencer: walks 4-byte windows, accumulates prefix runs longer than
// one window, enforces the prefix-length limit and hands the result downstream.
module prefix_ctl
    import prefix_ctl_pkg::*;
#(
    parameter int PREF   = pref_width,
    parameter int MAXPRF = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            mode64,
    input  logic            in_valid,
    input  logic [31:0]     in_bits,
    output logic            in_ready,
    output logic [2:0]      in_consume,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PREF-1:0] out_pref,
    output logic [3:0]      out_len,
    output logic            out_err
);

    prfctl_state_t   r_state, w_state_next;
    logic [PREF-1:0] r_acc_pref, w_acc_pref_next;
    logic [3:0]      r_acc_len, w_acc_len_next;
    logic [PREF-1:0] r_out_pref, w_out_pref_next;
    logic [3:0]      r_out_len, w_out_len_next;
    logic            r_out_err, w_out_err_next;

    logic [2:0]      w_n;
    logic [PREF-1:0] w_win_pref;
    logic            w_rex_end;
    logic [4:0]      w_sum;
    logic [PREF-1:0] w_merged;

    prefix_ctl_prefix u_prefix (
        .i_bits    (in_bits),
        .i_mode64  (mode64),
        .o_bytes   (w_n),
        .o_pref    (w_win_pref),
        .o_rex_end (w_rex_end)
    );

    assign w_sum    = {1'b0, r_acc_len} + {2'b00, w_n};
    assign w_merged = prf_merge(r_acc_pref, w_win_pref);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PRFCTL_SCAN;
            r_acc_pref <= '0;
            r_acc_len  <= '0;
            r_out_pref <= '0;
            r_out_len  <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_acc_pref <= w_acc_pref_next;
            r_acc_len  <= w_acc_len_next;
            r_out_pref <= w_out_pref_next;
            r_out_len  <= w_out_len_next;
            r_out_err  <= w_out_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_acc_pref_next = r_acc_pref;
        w_acc_len_next  = r_acc_len;
        w_out_pref_next = r_out_pref;
        w_out_len_next  = r_out_len;
        w_out_err_next  = r_out_err;
        in_consume      = 3'd0;
        in_ready        = (r_state == PRFCTL_SCAN) && !flush;

        if (flush) begin
            w_state_next    = PRFCTL_SCAN;
            w_acc_pref_next = '0;
            w_acc_len_next  = '0;
            w_out_pref_next = '0;
            w_out_len_next  = '0;
            w_out_err_next  = 1'b0;
        end else begin
            case (r_state)
                PRFCTL_SCAN: begin
                    if (in_valid) begin
                        in_consume = w_n;
                        if (w_sum > 5'(MAXPRF)) begin
                            w_state_next    = PRFCTL_ERR;
                            w_out_err_next  = 1'b1;
                            w_out_len_next  = 4'd15;
                            w_out_pref_next = '0;
                        end else if ((w_n == 3'd4) && !w_rex_end) begin
                            w_acc_pref_next = w_merged;
                            w_acc_len_next  = w_sum[3:0];
                        end else begin
                            w_state_next    = PRFCTL_DONE;
                            w_out_pref_next = w_merged;
                            w_out_len_next  = w_sum[3:0];
                        end
                    end
                end
                default: begin
                    // Result holds until the opcode decoder takes it.
                    if (out_ready) begin
                        w_state_next    = PRFCTL_SCAN;
                        w_acc_pref_next = '0;
                        w_acc_len_next  = '0;
                        w_out_pref_next = '0;
                        w_out_len_next  = '0;
                        w_out_err_next  = 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = (r_state != PRFCTL_SCAN);
    assign out_pref  = r_out_pref;
    assign out_len   = r_out_len;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_prefix_ctl.sv
// Directed bench for prefix_ctl: hand-computed windows, consume counts and
// merged prefix vectors, including stall, overflow, flush and async reset.
module tb_prefix_ctl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mode64;
    logic        in_valid;
    logic [31:0] in_bits;
    logic        in_ready;
    logic [2:0]  in_consume;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_pref;
    logic [3:0]  out_len;
    logic        out_err;

    int cmp_cnt = 0;
    int err_cnt = 0;

    prefix_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .mode64     (mode64),
        .in_valid   (in_valid),
        .in_bits    (in_bits),
        .in_ready   (in_ready),
        .in_consume (in_consume),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pref   (out_pref),
        .out_len    (out_len),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        // Small inline reporter; each caller still states its own expectation.
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    task automatic ack_result;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; mode64 = 1'b0; in_valid = 1'b0;
        in_bits = 32'h0; out_ready = 1'b0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_len",   32'(out_len),   32'd0);
        chk("reset_out_pref",  32'(out_pref),  32'd0);
        chk("reset_out_err",   32'(out_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("reset_in_ready",  32'(in_ready),  32'd1);
    endtask

    task automatic test_data_2byte;
        mode64 = 1'b0;
        in_valid = 1'b1; in_bits = 32'h9090_0F66;
        #1;
        chk("t2b_consume",   32'(in_consume), 32'd2);
        chk("t2b_in_ready",  32'(in_ready),   32'd1);
        chk("t2b_no_valid",  32'(out_valid),  32'd0);
        tick();
        in_valid = 1'b0;
        chk("t2b_out_valid", 32'(out_valid),  32'd1);
        chk("t2b_out_len",   32'(out_len),    32'd2);
        chk("t2b_out_pref",  32'(out_pref),   32'h0028);
        chk("t2b_out_err",   32'(out_err),    32'd0);
        ack_result();
        chk("t2b_released",  32'(out_valid),  32'd0);
    endtask

    task automatic test_no_prefix_stall;
        in_valid = 1'b1; in_bits = 32'h9090_908B;
        #1;
        chk("np_consume", 32'(in_consume), 32'd0);
        tick();
        chk("np_out_valid", 32'(out_valid), 32'd1);
        chk("np_out_len",   32'(out_len),   32'd0);
        chk("np_out_pref",  32'(out_pref),  32'd0);
        in_bits = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready),  32'd0);
            chk("stall_len",      32'(out_len),   32'd0);
            chk("stall_pref",     32'(out_pref),  32'd0);
        end
        ack_result();
        chk("np_released", 32'(out_valid), 32'd0);
    endtask

    task automatic test_multi_window_seg;
        mode64 = 1'b1;
        in_valid = 1'b1; in_bits = 32'h6766_F32E;
        #1;
        chk("mw_consume0", 32'(in_consume), 32'd4);
        tick();
        chk("mw_mid_valid", 32'(out_valid), 32'd0);
        in_bits = 32'h908B_4865;
        #1;
        chk("mw_consume1", 32'(in_consume), 32'd2);
        tick();
        in_valid = 1'b0;
        chk("mw_out_valid", 32'(out_valid), 32'd1);
        chk("mw_out_len",   32'(out_len),   32'd6);
        // repE|data|addr|hasseg|SEG=GS(5)|REX|W
        chk("mw_out_pref",  32'(out_pref),  32'h0EDC);
        ack_result();
    endtask

    task automatic test_overflow;
        mode64 = 1'b0;
        in_valid = 1'b1; in_bits = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ov_consume4", 32'(in_consume), 32'd4);
            tick();
            chk("ov_run_valid", 32'(out_valid), 32'd0);
        end
        in_bits = 32'h9066_6666;
        #1;
        chk("ov_consume3", 32'(in_consume), 32'd3);
        tick();
        in_valid = 1'b0;
        chk("ov_out_valid", 32'(out_valid), 32'd1);
        chk("ov_out_err",   32'(out_err),   32'd1);
        chk("ov_out_len",   32'(out_len),   32'd15);
        chk("ov_out_pref",  32'(out_pref),  32'd0);
        ack_result();
        chk("ov_err_clear", 32'(out_err),   32'd0);
    endtask

    task automatic test_rex_mode;
        mode64 = 1'b0;
        in_valid = 1'b1; in_bits = 32'h9090_9048;
        #1;
        chk("rex32_consume", 32'(in_consume), 32'd0);
        tick();
        chk("rex32_len",  32'(out_len),  32'd0);
        chk("rex32_pref", 32'(out_pref), 32'd0);
        ack_result();
        mode64 = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("rex64_consume", 32'(in_consume), 32'd1);
        tick();
        chk("rex64_len",  32'(out_len),  32'd1);
        chk("rex64_pref", 32'(out_pref), 32'h0C00);
        ack_result();
    endtask

    task automatic test_flush;
        mode64 = 1'b0;
        in_valid = 1'b1; in_bits = 32'hF3F3_F3F3;
        tick();
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_scan_no_valid", 32'(out_valid), 32'd0);
        in_bits = 32'h9090_9066;
        #1;
        chk("fl_consume", 32'(in_consume), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("fl_out_len",  32'(out_len),  32'd1);
        chk("fl_out_pref", 32'(out_pref), 32'h0008);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_done_valid", 32'(out_valid), 32'd0);
        chk("fl_done_len",   32'(out_len),   32'd0);
        tick();
        chk("fl_stays_idle", 32'(out_valid), 32'd0);
    endtask

    task automatic test_async_rst;
        mode64 = 1'b0;
        in_valid = 1'b1; in_bits = 32'h6666_6666;
        tick();
        in_bits = 32'h9090_9066;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_len",   32'(out_len),   32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_len",   32'(out_len),   32'd0);
        chk("ar_pref",  32'(out_pref),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_after_valid", 32'(out_valid), 32'd0);
        // Mid-run reset: the accumulated run must be forgotten.
        in_valid = 1'b1; in_bits = 32'h6666_6666;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_bits = 32'h9090_908B;
        tick();
        in_valid = 1'b0;
        chk("ar_mid_valid", 32'(out_valid), 32'd1);
        chk("ar_mid_len",   32'(out_len),   32'd0);
        chk("ar_mid_pref",  32'(out_pref),  32'd0);
        ack_result();
    endtask

    initial begin
        test_reset();
        test_data_2byte();
        test_no_prefix_stall();
        test_multi_window_seg();
        test_overflow();
        test_rex_mode();
        test_flush();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/prefix_ctl.md
# prefix_ctl

Sequencer for the x86 legacy/REX prefix datapath in the hardware-translation front end. Each cycle it presents a 4-byte window at the current instruction pointer to one `prefix` decoder, accumulates prefix state across windows when a run of prefixes exceeds 4 bytes, and enforces the 14-prefix-byte architectural limit. It tells the fetch aligner how many bytes to consume, then hands the merged prefix vector and prefix length to the opcode decoder over a valid/ready handshake.

## Interface
- `PREF`, default `pref_width`: width of the prefix vector (bit layout from `struct.sv`).
- `MAXPRF`, default 14: maximum legal prefix byte count.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `flush`  in  1  synchronous abort; highest priority.
- `mode64`  in  1  long mode; REX (0x40–0x4f) is a prefix only when set.
- `in_valid`  in  1  `in_bits` holds ≥4 valid bytes at IP.
- `in_bits`  in  32  window; byte 0 = `in_bits[7:0]` = lowest address.
- `in_ready`  out  1  window consumed this cycle.
- `in_consume`  out  3  bytes to advance IP (0..4); meaningful only when `in_valid & in_ready`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  opcode decoder accepts.
- `out_pref`  out  PREF  merged prefix vector.
- `out_len`  out  4  prefix byte count 0..14; 15 on error.
- `out_err`  out  1  prefix run exceeded MAXPRF.

## Operation
- States: SCAN, DONE, ERR. Reset/flush: SCAN, acc_pref=0, acc_len=0, out_valid=0, out_err=0, out_len=0, out_pref=0.
- `in_ready = (state==SCAN) & ~flush`.
- SCAN, `in_valid`: decoder yields n = `prf_bytes` (0..4) and `pref` for the window; sum = acc_len + n (5-bit).
  - sum > MAXPRF: `in_consume`=n; go ERR; out_err=1, out_len=15, out_pref=0.
  - n==4 and window does not end with a REX (decoder's REX-terminates rule): `in_consume`=4; acc_len=sum; merge pref into acc_pref; stay SCAN.
  - otherwise (n<4 or REX ended the run): `in_consume`=n; load out_pref=merge(acc_pref,pref), out_len=sum; go DONE.
- Merge rule: bitwise OR of all flags, except the SEG field. If the new chunk has `pref_HASSEG`, SEG is taken from the new chunk (last segment override wins). REX fields W/R/X/B always come from the REX byte, which is the last prefix byte by construction.
- SCAN, `~in_valid`: hold state and accumulators; `in_consume`=0.
- DONE/ERR: out_valid=1. On `out_ready`, go SCAN next cycle with accumulators cleared and out_valid=0. Outputs remain stable while out_valid & ~out_ready.
- `pref_2byte` (0x0f) is passed through as a flag; opcode-map selection belongs downstream.
- `mode64` is sampled per window. A change mid-run is not legal; it must be preceded by `flush`.

## Timing
- Consume decision is combinational in the same cycle as the window (in_valid→in_ready/in_consume, no register).
- Result is registered: out_valid rises 1 cycle after the terminating window. Latency = ceil((len+1)/4) cycles plus 1.
- No new window is consumed while out_valid=1, so throughput is ≤1 instruction per 2 cycles.
- `flush` in any state: next cycle is SCAN with cleared accumulators. In_ready=0 in the flush cycle. A pending output is discarded.
- Async `rst` mid-run: all state clears immediately. No partial result appears after release.

## Structure
- `struct.sv` gains the state encoding macros (`prfctl_SCAN`/`DONE`/`ERR`) and `MAXPRF`. Prefix bit positions (`pref_*`) are already there.
- One sub-module: the existing `prefix` decoder, instantiated once on `in_bits`. The merge logic, 5-bit length adder and FSM are written in this block.

## Test plan
- Window 66 0f xx xx, mode64=0 → in_consume=2; one cycle later out_valid, out_len=2, pref_data=1, pref_2byte=1.
- Window 8b .. (no prefix) → in_consume=0, out_len=0, out_pref=0. Stall out_ready 3 cycles → outputs stable, in_ready=0.
- Windows 2e f3 66 67 then 65 48 8b .., mode64=1 → consume 4 then 2; out_len=6, SEG=5 (second override wins), W=1, repE/data/addr set.
- Windows of 66×4, 66×4, 66×4, then 66 66 66 x → consume 4,4,4,3; out_err=1, out_len=15.
- Mode64=0, window 48 90 → 0x48 is not a prefix, out_len=0. Same with mode64=1 → out_len=1, W=1.
- Flush asserted in SCAN after one full-prefix window, and again in DONE → no out_valid. Next window's result excludes the earlier prefixes. Async rst mid-run → all outputs 0.
